rr_mux_select_sequencer: RTL

Round-robin select sequencer that directly drives the 2-bit select S of the team's 4:1 multiplexer (multiplexer_4x1).
- Arbitrates four channel requests and presents a registered select, one-hot grant and valid.
- Bounds per-channel hold time and inserts a dead cycle between grants, so the downstream mux output never switches inside a valid window.

---
 rtl/rr_mux_select_sequencer_if.sv | 13 +
 rtl/rr_mux_select_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_select_sequencer_if.sv
// Select/handshake bundle between the round-robin sequencer and its users.
// The sequencer side (master) consumes requests and drives the mux select,
// the one-hot grant, valid and the round-robin pointer.
interface rr_mux_select_sequencer_if;
  logic [3:0] req;
  logic [1:0] S;
  logic [3:0] grant;
  logic       valid;
  logic [1:0] last_ch;

  modport master (input req, output S, output grant, output valid, output last_ch);
  modport slave  (output req, input S, input grant, input valid, input last_ch);
endinterface

// File: rtl/rr_mux_select_sequencer.sv
// Round-robin select sequencer driving the 2-bit select of multiplexer_4x1.
// Each grant is bounded to MAX_HOLD valid cycles and followed by GAP_CYCLES
// dead cycles, during which S keeps the released channel so Y stays stable.
// Optional macro RR_MUX_STRICT_CH0_EN gives channel 0 strict priority and
// lets a ch0 request cut short any other channel's grant.
module rr_mux_select_sequencer #(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  rr_mux_select_sequencer_if.master   bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [3:0]    GAP_C      = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    s_q, s_d;
  logic [3:0]    grant_q, grant_d;
  logic          valid_q, valid_d;
  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    gap_q, gap_d;

  logic          arb_found;
  logic [1:0]    arb_winner;
  logic          release_now;

  // Returns {found, winner}: first requester after the last released channel.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
`ifdef RR_MUX_STRICT_CH0_EN
    if (r[0]) res = 3'b100;
`endif
    return res;
  endfunction

  // Winner of the current request vector, used in IDLE and on the last gap cycle.
  always_comb begin
    {arb_found, arb_winner} = arbitrate(bus.req, last_q);
  end

  // Release condition for the channel currently holding the mux.
  always_comb begin
    release_now = !bus.req[s_q] || (hold_q == MAX_HOLD_C);
`ifdef RR_MUX_STRICT_CH0_EN
    if (s_q != 2'd0 && bus.req[0]) release_now = 1'b1;
`endif
  end

  // Next-state and next-output computation for the IDLE/GRANT/GAP sequencer.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    grant_d = grant_q;
    valid_d = valid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          s_d     = arb_winner;
          grant_d = 4'b0001 << arb_winner;
          valid_d = 1'b1;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = GAP;
          valid_d = 1'b0;
          grant_d = 4'b0000;
          last_d  = s_q;
          gap_d   = 4'd1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_C) begin
          if (arb_found) begin
            state_d = GRANT;
            s_d     = arb_winner;
            grant_d = 4'b0001 << arb_winner;
            valid_d = 1'b1;
            hold_d  = HW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = 4'b0000;
      end
    endcase
  end

  // State and registered outputs; reset points last_ch at ch3 so ch0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 2'b00;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      last_q  <= 2'b11;
      hold_q  <= '0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.grant   = grant_q;
  assign bus.valid   = valid_q;
  assign bus.last_ch = last_q;

endmodule
